// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin arbiter and phase sequencer for the shared
// snooping bus between two processor caches and main memory. A transaction
// steps through GRANT, an optional SNOOP, then a FLUSH or MEM phase, and ends
// with DONE. Every output is decoded from registered state only.
module snoop_bus_arbiter #(
  parameter logic [1:0] ReadMiss    = 2'd1,
  parameter logic [1:0] WriteMiss   = 2'd2,
  parameter logic [1:0] WriteBack   = 2'd3,
  parameter int         MEM_LATENCY = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic       snoop_hit,
  output logic [1:0] grant,
  output logic [1:0] bus_op,
  output logic       snoop_en,
  output logic [1:0] flush,
  output logic       mem_en,
  output logic       mem_we,
  output logic [1:0] done,
  output logic       busy
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SNOOP,
    S_FLUSH,
    S_MEM,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic          winner_reg, winner_next;  // 0 = PC0, 1 = PC1
  logic          last_reg, last_next;      // most recent winner
  logic [1:0]    op_reg, op_next;          // opcode latched at the win
  logic [CW-1:0] cnt_reg, cnt_next;        // cycles spent in FLUSH/MEM

  // State and transaction registers; last starts at PC1 so PC0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      winner_reg <= 1'b0;
      last_reg   <= 1'b1;
      op_reg     <= 2'b00;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      last_reg   <= last_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic: arbitration in IDLE, then phase sequencing of the latched transaction.
  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    last_next   = last_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the cache that did not win last time goes next.
          if (req == 2'b11) winner_next = ~last_reg;
          else              winner_next = req[1];
          op_next    = winner_next ? op1 : op0;
          last_next  = winner_next;
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (op_reg == WriteBack) begin
          state_next = S_MEM;
          cnt_next   = '0;
        end else begin
          state_next = S_SNOOP;
        end
      end
      S_SNOOP: begin
        if (snoop_hit) begin
          state_next = S_FLUSH;
          cnt_next   = '0;
        end else if (op_reg == ReadMiss || op_reg == WriteMiss) begin
          state_next = S_MEM;
          cnt_next   = '0;
        end else begin
          // Unrecognized opcode: invalidate-only, nothing to fetch.
          state_next = S_DONE;
        end
      end
      S_FLUSH, S_MEM: begin
        if (cnt_reg == CNT_LAST) state_next = S_DONE;
        else                     cnt_next   = cnt_reg + 1'b1;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Scalar strobes decoded from the registered state.
  always_comb begin
    busy     = (state_reg != S_IDLE);
    bus_op   = busy ? op_reg : 2'b00;
    snoop_en = (state_reg == S_SNOOP);
    mem_en   = (state_reg == S_MEM) || (state_reg == S_FLUSH);
    mem_we   = (state_reg == S_FLUSH) || ((state_reg == S_MEM) && (op_reg == WriteBack));
  end

  // Per-cache one-hot strobes; the flush owner is always the non-granted cache.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic is_winner;
      assign is_winner = (winner_reg == 1'(gi));
      assign grant[gi] = busy && is_winner;
      assign done[gi]  = (state_reg == S_DONE) && is_winner;
      assign flush[gi] = (state_reg == S_FLUSH) && !is_winner;
    end
  endgenerate

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Sequencer and arbiter for the shared snooping bus that connects the two processor caches (PC0, PC1) and main memory. It grants the bus to one cache at a time with round-robin fairness, and steps each bus transaction through its phases: grant, snoop, owner flush and memory access. It drives the one-hot strobes that tell the caches and the memory when to act. It sits between the caches' miss/write-back request logic and the bus/memory datapath.

## Interface
- `ReadMiss`, default 1: opcode for a read miss, which fetches a block.
- `WriteMiss`, default 2: opcode for a write miss, which fetches the block and invalidates other copies.
- `WriteBack`, default 3: opcode for a write-back of a modified block to memory.
- `MEM_LATENCY`, default 2: cycles per memory access, at least 1.
- `clock  in  1`: single clock; every register updates on its rising edge.
- `resetn  in  1`: synchronous, active-low reset.
- `req  in  2`: bus request per cache; bit i belongs to PCi.
- `op0`, `op1`  in  2 each: opcode of PC0 and PC1; valid while that cache's `req` is high.
- `snoop_hit  in  1`: the non-granted cache holds the block Modified; sampled in SNOOP.
- `grant  out  2`: one-hot; held from GRANT through DONE.
- `bus_op  out  2`: latched opcode of the current transaction; 0 when idle.
- `snoop_en  out  1`: one-cycle pulse in SNOOP; the non-granted cache checks its tags.
- `flush  out  2`: one-hot to the owner cache; held during FLUSH; the owner drives the block on the bus.
- `mem_en  out  1`: high during MEM and FLUSH.
- `mem_we  out  1`: high during FLUSH, and during MEM of a WriteBack.
- `done  out  2`: one-cycle pulse to the granted cache when its transaction ends.
- `busy  out  1`: high in every state except IDLE.

## Operation
States: IDLE, GRANT, SNOOP, FLUSH, MEM, DONE.

- **Reset** (`resetn`=0 at a rising edge): state=IDLE, all outputs 0, `bus_op`=0, cycle counter 0, `last`=1 so PC0 wins the first tie. Reset mid-transaction aborts it with no `done` pulse.
- **IDLE:**
  - If exactly one `req` bit is high, that cache wins.
  - If both are high, the cache that is not `last` wins.
  - On a win, latch the winner and its opcode, update `last` to the winner, go to GRANT.
  - With no request, stay in IDLE.
- **GRANT:** drive `grant` and `bus_op`.
  - Opcode WriteBack → MEM.
  - Otherwise → SNOOP.
- **SNOOP:** `snoop_en`=1; sample `snoop_hit`.
  - Hit → FLUSH; the owner is the other cache.
  - No hit with ReadMiss → MEM.
  - No hit with WriteMiss → MEM.
- **FLUSH:** `flush`[owner]=1, `mem_en`=1, `mem_we`=1 for MEM_LATENCY cycles.
  - Memory is updated and the requester captures the block from the bus.
  - Then → DONE; no separate memory read follows.
- **MEM:** `mem_en`=1 for MEM_LATENCY cycles; `mem_we`=1 only for WriteBack. Then → DONE.
- **DONE:** `done`[winner]=1 for one cycle, `grant` still held. Then → IDLE; `grant` and `bus_op` clear.
- **Opcode 0** (or any unrecognized opcode) is treated as WriteMiss without a memory access: SNOOP, then DONE on a miss or FLUSH on a hit.
- **Requester contract:**
  - A cache holds `req` and its opcode stable until it sees `done`.
  - It deasserts `req` on the edge where `done` is sampled.
  - `req` or `op` changes after GRANT are ignored; the latched transaction completes.
- **Cycle counter:** width `$clog2(MEM_LATENCY+1)`. Cleared on entry to FLUSH or MEM; the phase ends when count == MEM_LATENCY-1.

## Timing
- `req` high in IDLE at edge 0 → GRANT in cycle 1 → SNOOP in cycle 2.
- Latencies, measured as the `done` cycle relative to edge 0:
  - WriteMiss with no hit: 2+MEM_LATENCY+1.
  - ReadMiss with no hit: 3+MEM_LATENCY.
  - Snoop hit: 3+MEM_LATENCY.
  - WriteBack: 2+MEM_LATENCY (GRANT, MEM, DONE).
- Minimum gap between the `done` of one transaction and the GRANT of the next: one IDLE cycle.
- Back-to-back requests from both caches alternate strictly.
- `grant`, `flush` and `done` are never both-bits-high. `flush` never targets the granted cache.
- All outputs are registered (state-decoded from registered state); no combinational path from input to output.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles while `req`=2'b11 → all outputs 0, state IDLE; after release, `grant`=2'b01 two edges later.
- **ReadMiss, no hit, MEM_LATENCY=2:** PC1 `req` with `op1`=1, `snoop_hit`=0 → `grant`=10, `snoop_en` pulse in cycle 2, `mem_en` in cycles 3–4 with `mem_we`=0, `done`=10 in cycle 5.
- **Snoop hit:** PC0 ReadMiss with `snoop_hit`=1 in SNOOP → `flush`=10 and `mem_we`=1 for 2 cycles, then `done`=01; no MEM phase.
- **WriteBack:** PC0 `op0`=3 → no `snoop_en`; `mem_we`=1 in cycles 2–3; `done`=01 in cycle 4.
- **Fairness:** both `req` held continuously, each dropped for one cycle after its `done` → grant sequence 01, 10, 01, 10.
- **Abort:** `resetn`=0 during MEM → next cycle IDLE, no `done`, `mem_en`=0.
